// File: rtl/delay_timer_us.sv
// Delay timer driven by a one-per-microsecond tick: counts a requested number of
// us or ms units and reports completion with a single-cycle done pulse.
module delay_timer_us #(
  parameter int DELAY_W = 16,
  parameter int MS_DIV  = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_us,
  input  logic               start,
  input  logic               unit_ms,
  input  logic [DELAY_W-1:0] delay,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [DELAY_W-1:0] remaining,
  output logic [1:0]         dbg_state
);

  localparam int PS_W = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(MS_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COUNT  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DELAY_W-1:0] r_remaining;
  logic [DELAY_W-1:0] w_remaining_nxt;
  logic [PS_W-1:0]    r_prescale;
  logic [PS_W-1:0]    w_prescale_nxt;
  logic               r_unit_ms;
  logic               w_unit_ms_nxt;
  logic               w_unit_tick;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_prescale  <= '0;
      r_unit_ms   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_prescale  <= w_prescale_nxt;
      r_unit_ms   <= w_unit_ms_nxt;
    end
  end

  // A whole unit elapses on every tick in us mode, or on the tick that wraps
  // the prescaler in ms mode (wrap at MS_DIV-1, not a power of two).
  always_comb begin
    w_unit_tick = 1'b0;
    if (tick_us) begin
      w_unit_tick = r_unit_ms ? (r_prescale == PS_LAST) : 1'b1;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_prescale_nxt  = r_prescale;
    w_unit_ms_nxt   = r_unit_ms;
    case (r_state)
      S_IDLE, S_FINISH: begin
        w_state_nxt     = S_IDLE;
        w_remaining_nxt = '0;
        if (start) begin
          if (delay != '0) begin
            w_state_nxt     = S_COUNT;
            w_remaining_nxt = delay;
            w_unit_ms_nxt   = unit_ms;
            w_prescale_nxt  = '0;
          end else begin
            w_state_nxt = S_FINISH;
          end
        end
      end
      S_COUNT: begin
        // abort wins over a coincident terminal tick; start is ignored here
        if (abort) begin
          w_state_nxt     = S_IDLE;
          w_remaining_nxt = '0;
          w_prescale_nxt  = '0;
        end else if (tick_us) begin
          if (r_unit_ms) begin
            w_prescale_nxt = w_unit_tick ? '0 : r_prescale + 1'b1;
          end
          if (w_unit_tick) begin
            w_remaining_nxt = r_remaining - 1'b1;
            if (r_remaining == DELAY_W'(1)) begin
              w_state_nxt = S_FINISH;
            end
          end
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_remaining_nxt = '0;
        w_prescale_nxt  = '0;
      end
    endcase
  end

  assign busy      = (r_state == S_COUNT);
  assign done      = (r_state == S_FINISH);
  assign remaining = r_remaining;
  assign dbg_state = r_state;

endmodule
